// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, sends one framed byte
// on device-generated clocks, then samples the device acknowledge bit.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES       = 10000,
  parameter int SETUP_CYCLES         = 200,
  parameter int FILTER_LEN           = 8,
  parameter int FIRST_TIMEOUT_CYCLES = 1500000,
  parameter int BIT_TIMEOUT_CYCLES   = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       rx_inhibit,
  output logic       done,
  output logic       ack_ok,
  output logic       error,
  output logic [2:0] state_o
);

  // Handshake: a request is taken on any clock edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE, so at most one transaction is in flight.

  localparam int MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int MAX_B = (FIRST_TIMEOUT_CYCLES > BIT_TIMEOUT_CYCLES) ?
                         FIRST_TIMEOUT_CYCLES : BIT_TIMEOUT_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  localparam logic [CNT_W-1:0] INH_LAST  = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SET_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIRST_LIM = CNT_W'(FIRST_TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] BIT_LIM   = CNT_W'(BIT_TIMEOUT_CYCLES);
  localparam logic [FLT_W-1:0] FLT_LAST  = FLT_W'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [9:0]       frame_q, frame_d;
  logic             data_oe_q, data_oe_d;
  logic             first_q, first_d;
  logic             ack_q, ack_d;

  logic [1:0]       clk_sync_q, data_sync_q;
  logic             filt_q;
  logic [FLT_W-1:0] flt_cnt_q;
  logic             clk_s, data_s, fe;

  logic             clk_oe_w, data_oe_w, done_w, err_w, fe_ok;
  logic [CNT_W-1:0] limit;

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = filt_q && !clk_s && (flt_cnt_q == FLT_LAST);

  // Synchronisers idle high so reset never looks like a bus edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      flt_cnt_q   <= '0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
      data_sync_q <= {data_sync_q[0], ps2_data_in};
      if (clk_s == filt_q) begin
        flt_cnt_q <= '0;
      end else if (flt_cnt_q == FLT_LAST) begin
        filt_q    <= clk_s;
        flt_cnt_q <= '0;
      end else begin
        flt_cnt_q <= flt_cnt_q + FLT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      frame_q   <= '0;
      data_oe_q <= 1'b0;
      first_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      data_oe_q <= data_oe_d;
      first_q   <= first_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    data_oe_d = data_oe_q;
    first_d   = first_q;
    ack_d     = ack_q;
    clk_oe_w  = 1'b0;
    data_oe_w = 1'b0;
    done_w    = 1'b0;
    err_w     = 1'b0;
    fe_ok     = 1'b0;
    limit     = first_q ? FIRST_LIM : BIT_LIM;
    case (state_q)
      S_IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid) begin
          frame_d = {1'b1, ~^tx_data, tx_data};
          cnt_d   = '0;
          ack_d   = 1'b0;
          state_d = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        clk_oe_w = 1'b1;
        if (cnt_q == INH_LAST) begin
          cnt_d   = '0;
          state_d = S_REQ;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_REQ: begin
        clk_oe_w  = 1'b1;
        data_oe_w = 1'b1;
        if (cnt_q == SET_LAST) begin
          cnt_d     = '0;
          idx_d     = '0;
          first_d   = 1'b1;
          data_oe_d = 1'b1;
          state_d   = S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SEND: begin
        data_oe_w = data_oe_q;
        // The just-released clock may still be settling; ignore edges briefly.
        fe_ok = fe && !(first_q && (cnt_q < CNT_W'(2)));
        if (fe_ok) begin
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          first_d   = 1'b0;
          cnt_d     = '0;
          if (idx_q == 4'd9) state_d = S_ACK;
        end else if (cnt_q == limit) begin
          err_w     = 1'b1;
          data_oe_w = 1'b0;
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACK: begin
        if (fe) begin
          ack_d   = ~data_s;
          cnt_d   = '0;
          state_d = S_WAIT_IDLE;
        end else if (cnt_q == limit) begin
          err_w   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_IDLE: begin
        if (filt_q && data_s) begin
          done_w  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE) && !done_w && !err_w;
  assign rx_inhibit  = busy;
  assign done        = done_w;
  assign ack_ok      = done_w && ack_q;
  assign error       = err_w;
  assign ps2_clk_oe  = clk_oe_w;
  assign ps2_data_oe = data_oe_w;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model on an open-drain bus.
module tb_ps2_host_tx;

  localparam int P_INH   = 100;
  localparam int P_SET   = 20;
  localparam int P_FLT   = 8;
  localparam int P_FIRST = 3000;
  localparam int P_BIT   = 800;
  localparam int HALF    = 40;
  localparam int GAP     = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit, done, ack_ok, error;
  logic [2:0] state_o;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
  assign ps2_data_line = !(ps2_data_oe || dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES(P_INH), .SETUP_CYCLES(P_SET), .FILTER_LEN(P_FLT),
    .FIRST_TIMEOUT_CYCLES(P_FIRST), .BIT_TIMEOUT_CYCLES(P_BIT)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .rx_inhibit(rx_inhibit), .done(done), .ack_ok(ack_ok), .error(error),
    .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int viol     = 0;
  logic prev_term = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Continuous protocol invariants on busy/rx_inhibit/tx_ready around terminal pulses.
  always @(negedge clk) begin
    if (rst) begin
      prev_term <= 1'b0;
    end else begin
      if (rx_inhibit !== busy) viol <= viol + 1;
      if ((done || error) && busy) viol <= viol + 1;
      if (done && error) viol <= viol + 1;
      if (error && (ps2_clk_oe || ps2_data_oe)) viol <= viol + 1;
      if (prev_term && !tx_ready) viol <= viol + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (error) err_cnt <= err_cnt + 1;
      prev_term <= done || error;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_txn(input logic [7:0] d, input logic spurious,
                           output int inh, output int req);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    if (spurious) tx_data = ~d;
    else tx_valid = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_ready", tx_ready, 0);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < P_INH + 10) begin
      inh++;
      @(negedge clk);
    end
    req = 0;
    while (ps2_clk_oe && ps2_data_oe && req < P_SET + 10) begin
      req++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
  endtask

  // Device: generates n clocks, samples host data on each rising edge, drives ack.
  task automatic dev_clock(input int n, input logic nack, input logic glitch,
                           output logic start, output logic [9:0] bits);
    bits  = '0;
    start = ps2_data_line;
    repeat (GAP) @(negedge clk);
    for (int k = 0; k < n; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k < 10) bits[k] = ps2_data_line;
      if (k == 9 && !nack && n == 11) dev_data_low = 1'b1;
      if (k != n - 1) begin
        if (glitch) begin
          repeat (HALF / 2) @(negedge clk);
          dev_clk_low = 1'b1;
          repeat (3) @(negedge clk);
          dev_clk_low = 1'b0;
          repeat (HALF - HALF / 2 - 3) @(negedge clk);
        end else begin
          repeat (HALF) @(negedge clk);
        end
      end
    end
    dev_data_low = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] d, input logic nack, input logic glitch,
                         input logic [9:0] exp_frame, input logic exp_ack);
    int inh, req, d0, e0;
    logic start, got, ack_seen;
    logic [9:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    start_txn(d, glitch, inh, req);
    check("inhibit_len", inh, P_INH);
    check("req_len", req, P_SET);
    check("start_held_after_release", ps2_data_oe, 1);
    dev_clock(11, nack, glitch, start, bits);
    check("start_bit", start, 0);
    check("frame_bits", bits, exp_frame);
    got = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        ack_seen = ack_ok;
      end
    end
    check("done_seen", got, 1);
    check("ack_ok", ack_seen, exp_ack);
    @(negedge clk);
    check("ready_after_done", tx_ready, 1);
    check("done_count", done_cnt - d0, 1);
    check("error_count", err_cnt - e0, 0);
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [7:0] data;
    logic       nack;
    logic       glitch;
    logic [9:0] frame;
    logic       ack_ok;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int inh, req, t, d0, e0;
    logic start;
    logic [9:0] bits;

    vecs[0] = '{8'hED, 1'b0, 1'b0, 10'h3ED, 1'b1};
    vecs[1] = '{8'h00, 1'b1, 1'b0, 10'h300, 1'b0};
    vecs[2] = '{8'hFF, 1'b0, 1'b0, 10'h3FF, 1'b1};
    vecs[3] = '{8'h01, 1'b1, 1'b0, 10'h201, 1'b0};
    vecs[4] = '{8'h80, 1'b0, 1'b0, 10'h280, 1'b1};
    vecs[5] = '{8'hED, 1'b0, 1'b1, 10'h3ED, 1'b1};

    repeat (3) @(negedge clk);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_inhibit", rx_inhibit, 0);
    check("rst_clk_oe", ps2_clk_oe, 0);
    check("rst_data_oe", ps2_data_oe, 0);
    check("rst_pulses", {done, ack_ok, error}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 6; v++)
      run_txn(vecs[v].data, vecs[v].nack, vecs[v].glitch, vecs[v].frame, vecs[v].ack_ok);

    // Device never clocks: first-edge timeout.
    d0 = done_cnt;
    e0 = err_cnt;
    start_txn(8'hED, 1'b0, inh, req);
    check("tmo1_release_start_held", ps2_data_oe, 1);
    t = 0;
    while (!error && t < P_FIRST + 50) begin
      @(negedge clk);
      t++;
    end
    check("tmo1_latency", t, P_FIRST);
    check("tmo1_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    @(negedge clk);
    check("tmo1_ready_next", tx_ready, 1);
    check("tmo1_no_done", done_cnt - d0, 0);
    check("tmo1_error_count", err_cnt - e0, 1);
    repeat (5) @(negedge clk);

    // Device stops after four clocks: inter-bit timeout measured from the 4th bit on the wire.
    d0 = done_cnt;
    e0 = err_cnt;
    start_txn(8'h05, 1'b0, inh, req);
    dev_clock(3, 1'b0, 1'b0, start, bits);
    check("tmo2_bits_so_far", bits[2:0], 3'b101);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    t = 0;
    while (!ps2_data_oe && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("tmo2_bit3_applied", ps2_data_oe, 1);
    dev_clk_low = 1'b0;
    t = 0;
    while (!error && t < P_BIT + 50) begin
      @(negedge clk);
      t++;
    end
    check("tmo2_latency", t, P_BIT);
    @(negedge clk);
    check("tmo2_ready_next", tx_ready, 1);
    check("tmo2_no_done", done_cnt - d0, 0);
    check("tmo2_error_count", err_cnt - e0, 1);
    repeat (5) @(negedge clk);

    // Asynchronous reset in the middle of SEND.
    d0 = done_cnt;
    e0 = err_cnt;
    start_txn(8'h00, 1'b0, inh, req);
    dev_clock(4, 1'b0, 1'b0, start, bits);
    check("rstmid_data_oe_before", ps2_data_oe, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rstmid_clk_oe", ps2_clk_oe, 0);
    check("rstmid_data_oe", ps2_data_oe, 0);
    check("rstmid_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rstmid_ready", tx_ready, 1);
    check("rstmid_no_done", done_cnt - d0, 0);
    check("rstmid_no_error", err_cnt - e0, 0);
    run_txn(8'hED, 1'b0, 1'b0, 10'h3ED, 1'b1);

    repeat (5) @(negedge clk);
    check("protocol_invariants", viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
